// File: rtl/exception_ctrl.sv
// MEM-stage exception arbiter: prioritises interrupts and exception flags,
// latches the winner and presents one flush/redirect pulse to CP0 and fetch.
module exception_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_cache_stall,
   input  logic        mem_valid,
   input  logic [31:0] mem_pc,
   input  logic        mem_in_delayslot,
   input  logic [7:0]  mem_exc_flags,
   input  logic [31:0] mem_data_addr,
   input  logic [31:0] cp0_status,
   input  logic [31:0] cp0_cause,
   input  logic [31:0] cp0_epc,
   input  logic        wb_cp0_we,
   input  logic [4:0]  wb_cp0_waddr,
   input  logic [31:0] wb_cp0_wdata,
   output logic [31:0] excepttype_o,
   output logic [31:0] current_inst_addr_o,
   output logic        is_in_delayslot_o,
   output logic [31:0] bad_addr_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o
);

   typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_DRAIN} state_t;

   // Software-writable Cause bits: IP[1:0], IV, WP.
   localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

   state_t      state_q, state_d;
   logic [31:0] type_q, type_d;
   logic [31:0] pc_q, pc_d;
   logic        ds_q, ds_d;
   logic [31:0] bad_q, bad_d;
   logic [31:0] target_q, target_d;

   logic [31:0] status_fwd, cause_fwd, epc_fwd;
   logic        int_pending;
   logic        exc_hit;
   logic [31:0] exc_code, exc_bad;

   always_comb begin
      status_fwd = cp0_status;
      cause_fwd  = cp0_cause;
      epc_fwd    = cp0_epc;
      if (wb_cp0_we) begin
         if (wb_cp0_waddr == 5'd12) status_fwd = wb_cp0_wdata;
         if (wb_cp0_waddr == 5'd13) cause_fwd  = (cp0_cause & ~CAUSE_WMASK) | (wb_cp0_wdata & CAUSE_WMASK);
         if (wb_cp0_waddr == 5'd14) epc_fwd    = wb_cp0_wdata;
      end
   end

   assign int_pending = status_fwd[0] & ~status_fwd[1] & (|(cause_fwd[15:8] & status_fwd[15:8]));

   always_comb begin
      exc_hit  = 1'b1;
      exc_code = '0;
      exc_bad  = '0;
      if (int_pending)               exc_code = 32'h01;
      else if (mem_exc_flags[0]) begin
         exc_code = 32'h04;
         exc_bad  = mem_pc;
      end
      else if (mem_exc_flags[1])     exc_code = 32'h0a;
      else if (mem_exc_flags[2])     exc_code = 32'h0c;
      else if (mem_exc_flags[3])     exc_code = 32'h08;
      else if (mem_exc_flags[4])     exc_code = 32'h09;
      else if (mem_exc_flags[5])     exc_code = 32'h0e;
      else if (mem_exc_flags[6]) begin
         exc_code = 32'h04;
         exc_bad  = mem_data_addr;
      end
      else if (mem_exc_flags[7]) begin
         exc_code = 32'h05;
         exc_bad  = mem_data_addr;
      end
      else                           exc_hit  = 1'b0;
   end

   always_comb begin
      state_d  = state_q;
      type_d   = type_q;
      pc_d     = pc_q;
      ds_d     = ds_q;
      bad_d    = bad_q;
      target_d = target_q;
      if (!i_cache_stall) begin
         unique case (state_q)
            S_IDLE: begin
               if (mem_valid && exc_hit) begin
                  state_d  = S_COMMIT;
                  type_d   = exc_code;
                  pc_d     = mem_pc;
                  ds_d     = mem_in_delayslot;
                  bad_d    = exc_bad;
                  target_d = (exc_code == 32'h0e) ? epc_fwd : EXC_VECTOR;
               end
            end
            S_COMMIT: state_d = S_DRAIN;
            S_DRAIN:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         type_q   <= '0;
         pc_q     <= '0;
         ds_q     <= 1'b0;
         bad_q    <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         type_q   <= type_d;
         pc_q     <= pc_d;
         ds_q     <= ds_d;
         bad_q    <= bad_d;
         target_q <= target_d;
      end
   end

   // Outputs decode purely from registered state, so reset clears them without a clock.
   always_comb begin
      excepttype_o        = '0;
      current_inst_addr_o = '0;
      is_in_delayslot_o   = 1'b0;
      bad_addr_o          = '0;
      flush_o             = 1'b0;
      new_pc_o            = '0;
      if (state_q == S_COMMIT) begin
         excepttype_o        = type_q;
         current_inst_addr_o = pc_q;
         is_in_delayslot_o   = ds_q;
         bad_addr_o          = bad_q;
         flush_o             = 1'b1;
         new_pc_o            = target_q;
      end
   end

endmodule

// File: tb/tb_exception_ctrl.sv
// Exception controller bench: directed scenarios plus random traffic, all
// checked against a priority-list reference model of the exception pulse.
module tb_exception_ctrl;

   localparam logic [31:0] VEC = 32'hBFC00380;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_cache_stall = 1'b0;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_pc = '0;
   logic        mem_in_delayslot = 1'b0;
   logic [7:0]  mem_exc_flags = '0;
   logic [31:0] mem_data_addr = '0;
   logic [31:0] cp0_status = '0, cp0_cause = '0, cp0_epc = '0;
   logic        wb_cp0_we = 1'b0;
   logic [4:0]  wb_cp0_waddr = '0;
   logic [31:0] wb_cp0_wdata = '0;
   logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
   logic        is_in_delayslot_o, flush_o;

   exception_ctrl #(.EXC_VECTOR(VEC)) dut (
      .clk(clk), .rst(rst), .i_cache_stall(i_cache_stall), .mem_valid(mem_valid),
      .mem_pc(mem_pc), .mem_in_delayslot(mem_in_delayslot), .mem_exc_flags(mem_exc_flags),
      .mem_data_addr(mem_data_addr), .cp0_status(cp0_status), .cp0_cause(cp0_cause),
      .cp0_epc(cp0_epc), .wb_cp0_we(wb_cp0_we), .wb_cp0_waddr(wb_cp0_waddr),
      .wb_cp0_wdata(wb_cp0_wdata), .excepttype_o(excepttype_o),
      .current_inst_addr_o(current_inst_addr_o), .is_in_delayslot_o(is_in_delayslot_o),
      .bad_addr_o(bad_addr_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Reference: pending pulse record plus cycles spent after the pulse.
   bit          m_pending;    // a recorded exception is currently being presented
   bit          m_draining;   // one quiet cycle after the pulse
   logic [31:0] m_type, m_pc, m_bad, m_tgt;
   logic        m_ds;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic void ref_exc(output bit hit, output logic [31:0] code,
                                   output logic [31:0] bad, output logic [31:0] tgt);
      logic [31:0] st, ca, ep;
      logic [7:0]  codes [8];
      bit          intr;
      codes = '{8'h04, 8'h0a, 8'h0c, 8'h08, 8'h09, 8'h0e, 8'h04, 8'h05};
      st = (wb_cp0_we && wb_cp0_waddr == 12) ? wb_cp0_wdata : cp0_status;
      ca = cp0_cause;
      if (wb_cp0_we && wb_cp0_waddr == 13)
         ca = (cp0_cause & 32'hFF3F_FCFF) | (wb_cp0_wdata & 32'h00C0_0300);
      ep = (wb_cp0_we && wb_cp0_waddr == 14) ? wb_cp0_wdata : cp0_epc;
      intr = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 0);
      hit  = intr || (mem_exc_flags != 0);
      code = 0;
      bad  = 0;
      if (intr) code = 1;
      else begin
         for (int i = 7; i >= 0; i--)
            if (mem_exc_flags[i]) begin
               code = {24'h0, codes[i]};
               bad  = (i == 0) ? mem_pc : (i >= 6) ? mem_data_addr : 32'h0;
            end
      end
      tgt = (code == 32'h0e) ? ep : VEC;
   endfunction

   task automatic model_step();
      bit hit;
      logic [31:0] c, b, t;
      if (!rst) begin
         m_pending = 0; m_draining = 0;
      end else if (!i_cache_stall) begin
         if (m_pending) begin
            m_pending = 0; m_draining = 1;
         end else if (m_draining) begin
            m_draining = 0;
         end else if (mem_valid) begin
            ref_exc(hit, c, b, t);
            if (hit) begin
               m_pending = 1;
               m_type = c; m_pc = mem_pc; m_ds = mem_in_delayslot; m_bad = b; m_tgt = t;
            end
         end
      end
   endtask

   task automatic check_outputs();
      chk("excepttype", excepttype_o,                m_pending ? m_type : 32'h0);
      chk("inst_addr",  current_inst_addr_o,         m_pending ? m_pc   : 32'h0);
      chk("delayslot",  {31'h0, is_in_delayslot_o},  {31'h0, m_pending ? m_ds : 1'b0});
      chk("bad_addr",   bad_addr_o,                  m_pending ? m_bad  : 32'h0);
      chk("flush",      {31'h0, flush_o},            {31'h0, m_pending});
      chk("new_pc",     new_pc_o,                    m_pending ? m_tgt  : 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic quiet();
      i_cache_stall = 0; mem_valid = 0; mem_pc = 0; mem_in_delayslot = 0;
      mem_exc_flags = 0; mem_data_addr = 0; cp0_status = 0; cp0_cause = 0;
      cp0_epc = 0; wb_cp0_we = 0; wb_cp0_waddr = 0; wb_cp0_wdata = 0;
   endtask

   task automatic instr(input logic [31:0] pc, input logic [7:0] flags, input logic [31:0] da);
      mem_valid = 1; mem_pc = pc; mem_exc_flags = flags; mem_data_addr = da;
   endtask

   task automatic rand_inputs();
      int unsigned r;
      i_cache_stall    = ($urandom % 4) == 0;
      mem_valid        = ($urandom % 8) != 0;
      mem_pc           = $urandom;
      mem_in_delayslot = 1'($urandom);
      mem_data_addr    = $urandom;
      r = $urandom % 8;
      if (r < 3)       mem_exc_flags = 8'(1 << ($urandom % 8));
      else if (r == 3) mem_exc_flags = 8'($urandom);
      else             mem_exc_flags = 0;
      cp0_status   = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
      cp0_cause    = (($urandom % 4) == 0) ? $urandom : ($urandom & 32'hFFFF_00FF);
      cp0_epc      = $urandom;
      wb_cp0_we    = 1'($urandom);
      wb_cp0_waddr = 5'(11 + $urandom % 5);
      wb_cp0_wdata = $urandom;
   endtask

   initial begin
      m_pending = 0; m_draining = 0;
      m_type = 0; m_pc = 0; m_bad = 0; m_tgt = 0; m_ds = 0;
      quiet();
      #1;
      check_outputs();
      @(negedge clk);
      rst = 1;

      // Syscall: one pulse, then drain, then idle.
      instr(32'hBFC00100, 8'h08, 32'h0);
      tick();
      chk("sys_type", excepttype_o, 32'h08);
      chk("sys_newpc", new_pc_o, 32'hBFC00380);
      chk("sys_pc", current_inst_addr_o, 32'hBFC00100);
      quiet();
      tick();
      chk("sys_drain_flush", {31'h0, flush_o}, 32'h0);
      tick();

      // Eret with forwarded EPC.
      instr(32'h400, 8'h20, 32'h0);
      cp0_epc = 32'h100; wb_cp0_we = 1; wb_cp0_waddr = 14; wb_cp0_wdata = 32'hBFC00200;
      tick();
      chk("eret_type", excepttype_o, 32'h0e);
      chk("eret_newpc", new_pc_o, 32'hBFC00200);
      quiet(); tick(); tick();

      // Priority / bad address.
      instr(32'h1002, 8'h41, 32'h2001);
      tick();
      chk("fetch_type", excepttype_o, 32'h04);
      chk("fetch_bad", bad_addr_o, 32'h1002);
      quiet(); tick(); tick();
      instr(32'h1002, 8'h80, 32'h2001);
      tick();
      chk("store_type", excepttype_o, 32'h05);
      chk("store_bad", bad_addr_o, 32'h2001);
      quiet(); tick(); tick();

      // Interrupt preempts overflow; masked by EXL.
      instr(32'h500, 8'h04, 32'h0);
      cp0_status = 32'h0000_0401; cp0_cause = 32'h0000_0400;
      tick();
      chk("int_type", excepttype_o, 32'h01);
      quiet(); tick(); tick();
      instr(32'h500, 8'h04, 32'h0);
      cp0_status = 32'h0000_0403; cp0_cause = 32'h0000_0400;
      tick();
      chk("int_masked_type", excepttype_o, 32'h0c);
      quiet(); tick(); tick();

      // No flags, no interrupt: nothing happens.
      instr(32'h600, 8'h00, 32'h0);
      tick();
      chk("noexc_flush", {31'h0, flush_o}, 32'h0);
      quiet();

      // Stall held for 3 cycles in COMMIT.
      instr(32'h700, 8'h10, 32'h0);
      tick();
      quiet();
      i_cache_stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_hold", excepttype_o, 32'h09);
      end
      i_cache_stall = 0;
      tick();
      chk("stall_release_flush", {31'h0, flush_o}, 32'h0);
      tick();

      // Asynchronous reset mid-COMMIT.
      instr(32'h800, 8'h08, 32'h0);
      tick();
      chk("pre_rst_flush", {31'h0, flush_o}, 32'h1);
      quiet();
      #2 rst = 0;
      #1;
      m_pending = 0; m_draining = 0;
      chk("rst_type", excepttype_o, 32'h0);
      chk("rst_flush", {31'h0, flush_o}, 32'h0);
      chk("rst_newpc", new_pc_o, 32'h0);
      chk("rst_pc", current_inst_addr_o, 32'h0);
      tick(); tick();
      rst = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_flush", {31'h0, flush_o}, 32'h0);
      end
      instr(32'h900, 8'h08, 32'h0);
      tick();
      chk("post_rst_detect", excepttype_o, 32'h08);
      quiet(); tick(); tick();

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         rand_inputs();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 The block SHALL provide these ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- i_cache_stall  in  1  pipeline freeze
- mem_valid  in  1  MEM-stage instruction valid
- mem_pc  in  32  MEM-stage instruction address
- mem_in_delayslot  in  1  instruction in branch delay slot
- mem_exc_flags  in  8  [0] fetch misaligned, [1] reserved inst, [2] overflow, [3] syscall, [4] break, [5] eret, [6] load misaligned, [7] store misaligned
- mem_data_addr  in  32  load/store effective address
- cp0_status, cp0_cause, cp0_epc  in  32 each  current CP0 values
- wb_cp0_we  in  1  pending mtc0 write
- wb_cp0_waddr  in  5  mtc0 target register
- wb_cp0_wdata  in  32  mtc0 data
- excepttype_o  out  32  code to CP0
- current_inst_addr_o  out  32  faulting PC
- is_in_delayslot_o  out  1  delay-slot flag
- bad_addr_o  out  32  BadVAddr value
- flush_o  out  1  pipeline flush
- new_pc_o  out  32  redirect target

REQ-002 Parameter EXC_VECTOR, default 32'hBFC00380, exception entry address.

Function
REQ-003 Forwarded CP0 values SHALL be used: when wb_cp0_we=1 and wb_cp0_waddr is 12/13/14, wb_cp0_wdata SHALL replace Status/Cause/EPC respectively. For Cause, only bits 9:8, 22 and 23 SHALL be replaced.
REQ-004 Interrupt pending SHALL be Status[0] & ~Status[1] & |(Cause[15:8] & Status[15:8]), computed on forwarded values.
REQ-005 Detection SHALL occur only in state IDLE with mem_valid=1 and i_cache_stall=0.
REQ-006 Priority, highest first, with excepttype code:
- interrupt 0x01
- fetch misaligned 0x04, bad_addr=mem_pc
- reserved 0x0a
- overflow 0x0c
- syscall 0x08
- break 0x09
- eret 0x0e
- load misaligned 0x04, bad_addr=mem_data_addr
- store misaligned 0x05, bad_addr=mem_data_addr
REQ-007 On detection, the block SHALL latch type, mem_pc, mem_in_delayslot, bad_addr and the target into registers, then go IDLE->COMMIT. Target is forwarded EPC for eret, else EXC_VECTOR.
REQ-008 In COMMIT, the outputs SHALL be driven from the latched registers, with flush_o=1.
REQ-009 On the first non-stalled cycle in COMMIT, the block SHALL go COMMIT->DRAIN.
REQ-010 In DRAIN: excepttype_o=0, flush_o=0, and no detection. On the next non-stalled cycle the block SHALL go DRAIN->IDLE.
REQ-011 In IDLE and DRAIN, excepttype_o, current_inst_addr_o, bad_addr_o and new_pc_o SHALL be 0, and is_in_delayslot_o=0.
REQ-012 While i_cache_stall=1, state and all registers SHALL hold. COMMIT outputs SHALL stay asserted, so CP0 samples exactly one non-stalled excepttype pulse per exception.
REQ-013 When multiple flags are set, only the highest-priority one SHALL be reported. Interrupt SHALL preempt any flag on the same instruction.
REQ-014 mem_exc_flags=0 with no interrupt SHALL produce no transition.
REQ-015 Latency: detection cycle N leads to excepttype_o and flush_o from cycle N+1 to the first non-stalled COMMIT cycle inclusive.

Reset
REQ-016 rst=0 SHALL asynchronously force IDLE and clear all registers and outputs to 0, including mid-COMMIT or mid-DRAIN. No pending exception SHALL survive reset.
REQ-017 After rst deasserts, detection SHALL be possible on the first rising edge.

Verification
REQ-018 Syscall: mem_pc=0xBFC00100, flags=0x08, no stall -> next cycle excepttype_o=0x08, flush_o=1, new_pc_o=0xBFC00380, current_inst_addr_o=0xBFC00100 for 1 cycle, then DRAIN, then IDLE.
REQ-019 Eret with forwarding: cp0_epc=0x100, wb_cp0_we=1, waddr=14, wdata=0xBFC00200, flags=0x20 -> excepttype_o=0x0e, new_pc_o=0xBFC00200.
REQ-020 Priority and bad address: flags=0x41 (fetch+load misaligned), mem_pc=0x1002, mem_data_addr=0x2001 -> excepttype_o=0x04, bad_addr_o=0x1002. A separate flags=0x80 case -> excepttype_o=0x05, bad_addr_o=0x2001.
REQ-021 Interrupt: Status=0x0000_0401, Cause[10]=1, flags=0x04 -> excepttype_o=0x01. Repeat with Status[1]=1 -> excepttype_o=0x0c.
REQ-022 Stall: i_cache_stall rises in COMMIT for 3 cycles -> outputs held 4 cycles, single COMMIT->DRAIN transition after stall drops.
REQ-023 Reset: rst=0 asserted mid-COMMIT -> all outputs 0 immediately (asynchronously, without waiting for a clock edge), state IDLE, and no pulse after release.
